// File: rtl/cpu_sfr_arb.sv
// cpu_sfr_arb: two-master arbiter/sequencer for the CPU SFR/IO bus.
`ifndef CPU_DATA_WIDTH
`define CPU_DATA_WIDTH 8
`endif
`ifndef CPU_ADDR_WIDTH
`define CPU_ADDR_WIDTH 8
`endif

module cpu_sfr_arb #(
  parameter int DATA_WIDTH = `CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = `CPU_ADDR_WIDTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  M0_REQ,
  input  logic                  M0_WE,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  output logic                  M0_ACK,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  input  logic                  M1_REQ,
  input  logic                  M1_WE,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  output logic                  M1_ACK,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  MEM_WR,
  output logic                  MEM_RD,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WR_DATA,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  output logic                  BUSY,
  output logic                  GNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                  state_q, state_d;
  logic                    last_q;
  logic                    we_q;
  logic                    gnt_vld;
  logic                    gnt_sel;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Next state and grant decision; the bus/output registers below are all
  // loaded from these so every output stays registered.
  always_comb begin
    state_d   = state_q;
    gnt_vld   = 1'b0;
    gnt_sel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (M0_REQ || M1_REQ) begin
          gnt_vld = 1'b1;
          if (M0_REQ && M1_REQ) gnt_sel = FIXED_PRIO ? 1'b0 : ~last_q;
          else                  gnt_sel = M1_REQ;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? ACK : WAIT;
      WAIT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sel_we    = gnt_sel ? M1_WE    : M0_WE;
    sel_addr  = gnt_sel ? M1_ADDR  : M0_ADDR;
    sel_wdata = gnt_sel ? M1_WDATA : M0_WDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      MEM_WR      <= 1'b0;
      MEM_RD      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WR_DATA <= '0;
      M0_ACK      <= 1'b0;
      M1_ACK      <= 1'b0;
      M0_RDATA    <= '0;
      M1_RDATA    <= '0;
      BUSY        <= 1'b0;
      GNT         <= 1'b0;
    end else begin
      MEM_WR <= 1'b0;
      MEM_RD <= 1'b0;
      M0_ACK <= 1'b0;
      M1_ACK <= 1'b0;
      BUSY   <= (state_d != IDLE);
      if (gnt_vld) begin
        we_q        <= sel_we;
        MEM_ADDR    <= sel_addr;
        MEM_WR_DATA <= sel_wdata;
        MEM_WR      <= sel_we;
        MEM_RD      <= ~sel_we;
        GNT         <= gnt_sel;
        last_q      <= gnt_sel;
      end
      if ((state_q == ISSUE && we_q) || state_q == WAIT) begin
        M0_ACK <= ~GNT;
        M1_ACK <= GNT;
      end
      if (state_q == WAIT) begin
        if (GNT) M1_RDATA <= MEM_RD_DATA;
        else     M0_RDATA <= MEM_RD_DATA;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sfr_arb.sv
// Bench for cpu_sfr_arb: round-robin and fixed-priority instances, each
// driven by random master traffic and checked against a transaction model.
module tb_cpu_sfr_arb;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          mem_wr [2];
  logic          mem_rd [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wr_data [2];
  logic [DW-1:0] mem_rd_data [2];
  logic          busy [2];
  logic          gnt  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_sfr_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(g == 1)) u_dut (
      .CLK(clk), .RST_N(rst_n),
      .M0_REQ(req[g][0]), .M0_WE(we[g][0]), .M0_ADDR(addr[g][0]), .M0_WDATA(wdata[g][0]),
      .M0_ACK(ack[g][0]), .M0_RDATA(rdata[g][0]),
      .M1_REQ(req[g][1]), .M1_WE(we[g][1]), .M1_ADDR(addr[g][1]), .M1_WDATA(wdata[g][1]),
      .M1_ACK(ack[g][1]), .M1_RDATA(rdata[g][1]),
      .MEM_WR(mem_wr[g]), .MEM_RD(mem_rd[g]), .MEM_ADDR(mem_addr[g]),
      .MEM_WR_DATA(mem_wr_data[g]), .MEM_RD_DATA(mem_rd_data[g]),
      .BUSY(busy[g]), .GNT(gnt[g]));

    // Registered-read slave memory.
    logic [DW-1:0] smem [256];
    always @(posedge clk) begin
      if (mem_wr[g]) smem[mem_addr[g]] <= mem_wr_data[g];
      if (mem_rd[g]) mem_rd_data[g] <= smem[mem_addr[g]];
    end
  end

  // Reference model state
  logic [DW-1:0] refmem [2][256];
  logic [DW-1:0] ref_rd [2][2];
  int            last_srv [2];
  bit            fixed [2] = '{1'b0, 1'b1};
  // Pending transaction per master
  bit            pv [2];
  logic          pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int d);
    if (pv[0] && pv[1]) return fixed[d] ? 0 : (last_srv[d] == 0 ? 1 : 0);
    return pv[1] ? 1 : 0;
  endfunction

  task automatic drive(input int d);
    for (int m = 0; m < 2; m++) begin
      req[d][m]   = pv[m];
      we[d][m]    = pwe[m];
      addr[d][m]  = paddr[m];
      wdata[d][m] = pdata[m];
    end
  endtask

  task automatic chk_quiet(input int d, input string tag);
    check({tag, "_wr"}, mem_wr[d], 0);
    check({tag, "_rd"}, mem_rd[d], 0);
    check({tag, "_ack0"}, ack[d][0], 0);
    check({tag, "_ack1"}, ack[d][1], 0);
  endtask

  task automatic chk_rdata(input int d, input string tag);
    check({tag, "_rdata0"}, rdata[d][0], ref_rd[d][0]);
    check({tag, "_rdata1"}, rdata[d][1], ref_rd[d][1]);
  endtask

  // Called at the negedge of an IDLE cycle with pins already driven.
  task automatic run_txn(input int d, input int w, input bit drop);
    logic          twe;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    twe = pwe[w]; ta = paddr[w]; td = pdata[w];
    @(negedge clk);
    check("issue_wr", mem_wr[d], twe);
    check("issue_rd", mem_rd[d], !twe);
    check("issue_addr", mem_addr[d], ta);
    check("issue_wdata", mem_wr_data[d], td);
    check("issue_busy", busy[d], 1);
    check("issue_gnt", gnt[d], w);
    check("issue_ack0", ack[d][0], 0);
    check("issue_ack1", ack[d][1], 0);
    addr[d][w]  = ta ^ 8'h10;
    wdata[d][w] = DW'($urandom);
    we[d][w]    = 1'($urandom);
    if (drop) req[d][w] = 1'b0;
    if (twe) refmem[d][ta] = td;
    if (!twe) begin
      @(negedge clk);
      chk_quiet(d, "wait");
      check("wait_busy", busy[d], 1);
      check("wait_addr", mem_addr[d], ta);
    end
    @(negedge clk);
    if (!twe) ref_rd[d][w] = refmem[d][ta];
    check("ack_win", ack[d][w], 1);
    check("ack_lose", ack[d][1-w], 0);
    check("ack_wr", mem_wr[d], 0);
    check("ack_rd", mem_rd[d], 0);
    check("ack_busy", busy[d], 1);
    check("ack_gnt", gnt[d], w);
    check("ack_addr", mem_addr[d], ta);
    chk_rdata(d, "ack");
    last_srv[d] = w;
    pv[w] = 1'b0;
    @(negedge clk);
    chk_quiet(d, "idle");
    check("idle_busy", busy[d], 0);
    chk_rdata(d, "idle");
  endtask

  task automatic do_one(input int d, input int m, input logic w_e, input logic [AW-1:0] a,
                        input logic [DW-1:0] dat, input bit drop);
    pv[0] = 1'b0; pv[1] = 1'b0;
    pv[m] = 1'b1; pwe[m] = w_e; paddr[m] = a; pdata[m] = dat;
    drive(d);
    run_txn(d, pick(d), drop);
  endtask

  task automatic random_phase(input int d, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pv[m] && $urandom_range(0, 99) < p) begin
          pv[m] = 1'b1; pwe[m] = 1'($urandom);
          paddr[m] = 8'h80 + AW'($urandom_range(0, 7)); pdata[m] = DW'($urandom);
        end
      drive(d);
      if (!pv[0] && !pv[1]) begin
        @(negedge clk);
        chk_quiet(d, "rnd_idle");
        check("rnd_idle_busy", busy[d], 0);
      end else begin
        run_txn(d, pick(d), 1'($urandom));
      end
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive(d);
  endtask

  task automatic reset_mid_read(input int d, input int m, input logic [AW-1:0] a);
    pv[0] = 1'b0; pv[1] = 1'b0;
    pv[m] = 1'b1; pwe[m] = 1'b0; paddr[m] = a; pdata[m] = 8'h00;
    drive(d);
    @(negedge clk);
    check("rst_issue_rd", mem_rd[d], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_quiet(k, "rst");
      check("rst_busy", busy[k], 0);
      check("rst_gnt", gnt[k], 0);
      check("rst_rdata0", rdata[k][0], 0);
      check("rst_rdata1", rdata[k][1], 0);
      ref_rd[k][0] = '0; ref_rd[k][1] = '0;
      last_srv[k] = 1;
    end
    @(negedge clk);
    chk_quiet(d, "rst_hold");
    rst_n = 1'b1;
    run_txn(d, m, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
        ref_rd[d][m] = '0;
      end
      last_srv[d] = 1;
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_quiet(d, "por");
      check("por_busy", busy[d], 0);
      check("por_gnt", gnt[d], 0);
      check("por_addr", mem_addr[d], 0);
      check("por_wdata", mem_wr_data[d], 0);
      chk_rdata(d, "por");
    end
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int a = 8'h80; a <= 8'h87; a++) do_one(d, a & 1, 1'b1, AW'(a), DW'($urandom), 1'b1);
      do_one(d, 0, 1'b1, 8'h90, 8'h5A, 1'b1);
      do_one(d, 1, 1'b0, 8'h90, 8'h00, 1'b1);
      check("tp_m1_rd", rdata[d][1], 8'h5A);
      do_one(d, 1, 1'b1, 8'hA0, 8'h3C, 1'b1);
      do_one(d, 0, 1'b0, 8'hA0, 8'h00, 1'b1);
      check("tp_a0_rd", rdata[d][0], 8'h3C);
      do_one(d, 0, 1'b1, 8'h80, 8'hFF, 1'b0);
      do_one(d, 0, 1'b0, 8'h80, 8'h00, 1'b0);
      check("tp_ff_rd", rdata[d][0], 8'hFF);
      random_phase(d, 60, 50);
      random_phase(d, 30, 100);
      reset_mid_read(d, d, 8'h90);
      random_phase(d, 40, 60);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
